// File: rtl/alu4_share_ctrl_if.sv
// Bus between the two operation requesters, the shared ALU and the arbiter/sequencer.
// The slave modport is the controller's view; the master modport is the environment's.
interface alu4_share_ctrl_if #(
  parameter int W  = 4,
  parameter int SW = 2
);
  logic          REQ0_in;
  logic [W-1:0]  A0_in;
  logic [W-1:0]  B0_in;
  logic [SW-1:0] SEL0_in;
  logic          REQ1_in;
  logic [W-1:0]  A1_in;
  logic [W-1:0]  B1_in;
  logic [SW-1:0] SEL1_in;
  logic          GNT0_out;
  logic          GNT1_out;
  logic          DONE0_out;
  logic          DONE1_out;
  logic [W-1:0]  RES_out;
  logic          BUSY_out;
  logic [W-1:0]  ALU_A_out;
  logic [W-1:0]  ALU_B_out;
  logic [SW-1:0] ALU_SEL_out;
  logic [W-1:0]  ALU_Y_in;

  modport slave (
    input  REQ0_in, A0_in, B0_in, SEL0_in,
    input  REQ1_in, A1_in, B1_in, SEL1_in,
    input  ALU_Y_in,
    output GNT0_out, GNT1_out, DONE0_out, DONE1_out,
    output RES_out, BUSY_out, ALU_A_out, ALU_B_out, ALU_SEL_out
  );

  modport master (
    output REQ0_in, A0_in, B0_in, SEL0_in,
    output REQ1_in, A1_in, B1_in, SEL1_in,
    output ALU_Y_in,
    input  GNT0_out, GNT1_out, DONE0_out, DONE1_out,
    input  RES_out, BUSY_out, ALU_A_out, ALU_B_out, ALU_SEL_out
  );
endinterface

// File: rtl/alu4_share_ctrl.sv
// Round-robin arbiter and sequencer that lets two requesters share one combinational ALU.
// Operands are registered onto the ALU, held HOLD_CYCLES clocks, then Y is captured.
module alu4_share_ctrl #(
  parameter int W           = 4,
  parameter int SW          = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic               CLK_in,
  input  logic               RST_n_in,
  alu4_share_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [SW-1:0] alu_sel_q, alu_sel_d;
  logic          win_s;

  // Winner: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    if (bus.REQ0_in && bus.REQ1_in) begin
      win_s = ptr_q;
    end else begin
      win_s = bus.REQ1_in;
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ0_in || bus.REQ1_in) begin
          owner_d   = win_s;
          alu_a_d   = win_s ? bus.A1_in   : bus.A0_in;
          alu_b_d   = win_s ? bus.B1_in   : bus.B0_in;
          alu_sel_d = win_s ? bus.SEL1_in : bus.SEL0_in;
          cnt_d     = HOLD_LOAD;
          gnt0_d    = ~win_s;
          gnt1_d    = win_s;
          state_d   = EXEC;
        end else begin
          state_d   = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
        end else begin
          // Priority flips away from whoever just finished.
          res_d   = bus.ALU_Y_in;
          done0_d = ~owner_q;
          done1_d = owner_q;
          ptr_d   = ~owner_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; async reset discards any in-flight op.
  always_ff @(posedge CLK_in or negedge RST_n_in) begin
    if (!RST_n_in) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= 4'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
      res_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
      res_q     <= res_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  assign bus.GNT0_out    = gnt0_q;
  assign bus.GNT1_out    = gnt1_q;
  assign bus.DONE0_out   = done0_q;
  assign bus.DONE1_out   = done1_q;
  assign bus.RES_out     = res_q;
  assign bus.BUSY_out    = busy_q;
  assign bus.ALU_A_out   = alu_a_q;
  assign bus.ALU_B_out   = alu_b_q;
  assign bus.ALU_SEL_out = alu_sel_q;

endmodule
